// File: rtl/pat_pkg.sv
// ---------------------------------------------------------------------------
// pat_pkg
// Shared definitions for the PAT instruction-buffer loader.
//   - default geometry of the instruction buffer (address width, instruction
//     width, instructions per line, line-count width)
//   - loader_bpw(): bytes needed to fill one buffer line
//   - LOADER_BPW: bytes per line for the default geometry
//   - loader_state_t: loader FSM states
//   - loader_checksum(): the byte that makes the 8-bit sum of a load zero
// ---------------------------------------------------------------------------
package pat_pkg;

    localparam int unsigned PAT_I_ADR_WIDTH   = 10;
    localparam int unsigned PAT_I_WIDTH       = 20;
    localparam int unsigned PAT_I_BUFFER_SIZE = 2;
    localparam int unsigned PAT_CNT_WIDTH     = 11;
    localparam int unsigned PAT_LINE_W        = PAT_I_BUFFER_SIZE * PAT_I_WIDTH;

    // Bytes needed to cover a line; the top byte may be only partly used.
    function automatic int unsigned loader_bpw(input int unsigned line_w);
        return (line_w + 7) / 8;
    endfunction

    localparam int unsigned LOADER_BPW = (PAT_LINE_W + 7) / 8;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COLLECT = 3'd1,
        LD_WRITE   = 3'd2,
        LD_CHECK   = 3'd3,
        LD_DONE    = 3'd4
    } loader_state_t;

    // Two's complement of the running sum: adding it to the sum gives 0 mod 256.
    function automatic logic [7:0] loader_checksum(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// ---------------------------------------------------------------------------
// imem_word_assembler
// Packs a byte stream little-endian into one instruction-buffer line:
// the k-th accepted byte lands in line_out[8k+7:8k]. Bits of the top byte
// that fall above LINE_W are dropped.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low reset (index and data cleared)
//   clear     in   restart at byte 0 (data register is left untouched so a
//                  completed line stays stable while it is written)
//   accept    in   byte_in is consumed this cycle
//   byte_in   in   data byte
//   full      out  the byte accepted this cycle completes the line
//   line_out  out  packed line (LINE_W bits)
// ---------------------------------------------------------------------------
module imem_word_assembler
    import pat_pkg::*;
#(
    parameter int unsigned LINE_W = PAT_LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic              full,
    output logic [LINE_W-1:0] line_out
);

    localparam int unsigned BPW   = loader_bpw(LINE_W);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BPW*8-1:0] pack_q, pack_d;
    logic [BPW-1:0]   lane_we;

    // One write enable per byte lane, decoded from the byte index.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign lane_we[gi] = accept && (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign full = accept && (idx_q == LAST_IDX);

    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < BPW; k++) begin
            if (lane_we[k]) begin
                pack_d[k*8 +: 8] = byte_in;
            end
        end
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = full ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pack_q <= pack_d;
        end
    end

    assign line_out = pack_q[LINE_W-1:0];

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Bulk-loads the PAT instruction buffer from a byte-wide host stream.
// Bytes are packed into lines of I_BUFFER_SIZE*I_WIDTH bits and written to
// consecutive line addresses starting at load_base (wrapping at the top of
// the address space). The PAT is held in reset (pat_hold) until a load
// finishes without error.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last line one
// extra byte is expected that makes the 8-bit sum of all data bytes zero;
// a mismatch sets err and keeps pat_hold high.
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-low reset
//   load_start      in   start pulse, honoured only when idle
//   load_base       in   first line address (latched on start)
//   load_count      in   number of lines (latched on start)
//   abort           in   cancel the load in progress
//   byte_in/valid   in   host byte stream
//   byte_ready      out  byte is accepted when byte_valid && byte_ready
//   imem_write_adr  out  line address
//   imem_write      out  one-cycle write strobe
//   imem_in         out  packed line data
//   pat_hold        out  1 = keep the PAT in reset
//   busy            out  load in progress
//   done            out  one-cycle pulse at the end of a load
//   err             out  sticky error, cleared by the next accepted start
// All outputs are registered.
// ---------------------------------------------------------------------------
module imem_loader
    import pat_pkg::*;
#(
    parameter int unsigned I_ADR_WIDTH   = PAT_I_ADR_WIDTH,
    parameter int unsigned I_WIDTH       = PAT_I_WIDTH,
    parameter int unsigned I_BUFFER_SIZE = PAT_I_BUFFER_SIZE,
    parameter int unsigned CNT_WIDTH     = PAT_CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic [I_ADR_WIDTH-1:0]             load_base,
    input  logic [CNT_WIDTH-1:0]               load_count,
    input  logic                               abort,
    input  logic [7:0]                         byte_in,
    input  logic                               byte_valid,
    output logic                               byte_ready,
    output logic [I_ADR_WIDTH-1:0]             imem_write_adr,
    output logic                               imem_write,
    output logic [I_BUFFER_SIZE*I_WIDTH-1:0]   imem_in,
    output logic                               pat_hold,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int unsigned LINE_W = I_BUFFER_SIZE * I_WIDTH;

    loader_state_t          state_q, state_d;
    logic [I_ADR_WIDTH-1:0] adr_q, adr_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic                   err_q, err_d;
    logic                   pat_hold_q, pat_hold_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   imem_write_q, imem_write_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic byte_accept;
    logic asm_accept;
    logic asm_clear;
    logic asm_full;

    // abort wins over a byte offered in the same cycle: the byte stays with the host.
    assign byte_accept = byte_valid && byte_ready_q && !abort;
    assign asm_accept  = byte_accept && (state_q == LD_COLLECT);

    imem_word_assembler #(
        .LINE_W (LINE_W)
    ) u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear),
        .accept   (asm_accept),
        .byte_in  (byte_in),
        .full     (asm_full),
        .line_out (imem_in)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        err_d      = err_q;
        pat_hold_d = pat_hold_q;
        asm_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            LD_IDLE: begin
                if (load_start) begin
                    adr_d      = load_base;
                    rem_d      = load_count;
                    err_d      = 1'b0;
                    pat_hold_d = 1'b1;
                    asm_clear  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                    state_d    = (load_count == '0) ? LD_DONE : LD_COLLECT;
                end
            end
            LD_COLLECT: begin
                if (asm_accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_in;
`endif
                    if (asm_full) begin
                        state_d = LD_WRITE;
                    end
                end
            end
            LD_WRITE: begin
                // The strobe is up this cycle; step to the next line.
                adr_d     = adr_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                asm_clear = 1'b1;
                if (rem_q == CNT_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = LD_CHECK;
`else
                    state_d = LD_DONE;
`endif
                end else begin
                    state_d = LD_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (byte_accept) begin
                    if (byte_in != loader_checksum(sum_q)) begin
                        err_d = 1'b1;
                    end
                    state_d = LD_DONE;
                end
            end
`endif
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase

        if (abort && (state_q != LD_IDLE)) begin
            state_d    = LD_IDLE;
            err_d      = 1'b1;
            pat_hold_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        if (state_d == LD_DONE) begin
            pat_hold_d = err_d;
        end
        byte_ready_d = (state_d == LD_COLLECT) || (state_d == LD_CHECK);
        imem_write_d = (state_d == LD_WRITE);
        done_d       = (state_d == LD_DONE);
        busy_d       = (state_d != LD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= LD_IDLE;
            adr_q        <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
            pat_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            imem_write_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            pat_hold_q   <= pat_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            byte_ready_q <= byte_ready_d;
            imem_write_q <= imem_write_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign byte_ready     = byte_ready_q;
    assign imem_write_adr = adr_q;
    assign imem_write     = imem_write_q;
    assign pat_hold       = pat_hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: reset state, two-line loads, address wrap,
// host valid gaps, abort mid-line and during a write, start while busy,
// zero-line load, reset mid-load and (with LOADER_CHECKSUM_EN) checksum
// accept/reject. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 10;
    localparam int CW = 11;
    localparam int LW = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [CW-1:0] load_count = '0;
    logic          abort = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] imem_write_adr;
    logic          imem_write;
    logic [LW-1:0] imem_in;
    logic          pat_hold;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .load_base      (load_base),
        .load_count     (load_count),
        .abort          (abort),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .imem_write_adr (imem_write_adr),
        .imem_write     (imem_write),
        .imem_in        (imem_in),
        .pat_hold       (pat_hold),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [AW-1:0] wr_adr[$];
    logic [LW-1:0] wr_dat[$];
    int            done_cnt = 0;
    logic          hold_at_done = 1'b1;
    logic          err_at_done = 1'b1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Observe writes and done pulses in the middle of the cycle.
    always @(negedge clk) begin
        if (imem_write) begin
            wr_adr.push_back(imem_write_adr);
            wr_dat.push_back(imem_in);
            $display("write adr=0x%03h data=0x%010h", imem_write_adr, imem_in);
        end
        if (done) begin
            done_cnt++;
            hold_at_done = pat_hold;
            err_at_done  = err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        done_cnt = 0;
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
        load_start = 1'b1;
        load_base  = base;
        load_count = cnt;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
        byte_in    = b;
        byte_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = byte_ready;
            tick();
            n++;
        end
        if (!acc) check_val("byte_accept_timeout", 64'(acc), 64'd1);
    endtask

    // Sends cnt lines of incrementing bytes starting at 'first'; with the
    // checksum feature the matching checksum byte follows.
    task automatic send_lines(input int cnt, input logic [7:0] first, input bit gaps, input bit poke);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        for (int i = 0; i < cnt * 5; i++) begin
            b = first + 8'(i);
            if (poke && i == 2) begin
                load_start = 1'b1;
                load_base  = 10'h155;
                load_count = 11'd7;
            end
            send_byte(b, gaps ? (i % 3) + 1 : 0);
            load_start = 1'b0;
            sum = sum + b;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(~sum + 8'd1, 0);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check_val(tag, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [AW-1:0] a, input logic [LW-1:0] d);
        check_val({tag, "_adr"}, (i < wr_adr.size()) ? 64'(wr_adr[i]) : 64'hDEAD_0000, 64'(a));
        check_val({tag, "_dat"}, (i < wr_dat.size()) ? 64'(wr_dat[i]) : 64'hDEAD_0000, 64'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        // 1. reset
        reset = 1'b0;
        repeat (2) tick();
        check_val("rst_pat_hold", 64'(pat_hold), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_write", 64'(imem_write), 64'd0);
        check_val("rst_ready", 64'(byte_ready), 64'd0);
        reset = 1'b1;
        tick();

        // 2. two lines, valid held high
        clear_log();
        start_load(10'h010, 11'd2);
        check_val("t2_busy", 64'(busy), 64'd1);
        check_val("t2_hold_during", 64'(pat_hold), 64'd1);
        check_val("t2_ready", 64'(byte_ready), 64'd1);
        send_lines(2, 8'h01, 1'b0, 1'b0);
        wait_done("t2_done");
        check_val("t2_nwr", 64'(wr_adr.size()), 64'd2);
        check_wr("t2_w0", 0, 10'h010, 40'h05_0403_0201);
        check_wr("t2_w1", 1, 10'h011, 40'h0A_0908_0706);
        check_val("t2_hold_at_done", 64'(hold_at_done), 64'd0);
        check_val("t2_err", 64'(err_at_done), 64'd0);
        check_val("t2_hold_after", 64'(pat_hold), 64'd0);
        check_val("t2_idle", 64'(busy), 64'd0);

        // 3. address wrap, plus load_start while busy is ignored
        clear_log();
        start_load(10'h3FF, 11'd2);
        send_lines(2, 8'h11, 1'b0, 1'b1);
        wait_done("t3_done");
        check_val("t3_nwr", 64'(wr_adr.size()), 64'd2);
        check_wr("t3_w0", 0, 10'h3FF, 40'h15_1413_1211);
        check_wr("t3_w1", 1, 10'h000, 40'h1A_1918_1716);
        check_val("t3_err", 64'(err), 64'd0);
        check_val("t3_idle", 64'(busy), 64'd0);

        // 4. gaps in byte_valid
        clear_log();
        start_load(10'h200, 11'd2);
        send_lines(2, 8'h01, 1'b1, 1'b0);
        wait_done("t4_done");
        check_val("t4_nwr", 64'(wr_adr.size()), 64'd2);
        check_wr("t4_w0", 0, 10'h200, 40'h05_0403_0201);
        check_wr("t4_w1", 1, 10'h201, 40'h0A_0908_0706);

        // 5. abort after the third byte of line 0
        clear_log();
        start_load(10'h020, 11'd2);
        send_byte(8'h31, 0);
        send_byte(8'h32, 0);
        send_byte(8'h33, 0);
        byte_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check_val("t5_nwr", 64'(wr_adr.size()), 64'd0);
        check_val("t5_ndone", 64'(done_cnt), 64'd0);
        check_val("t5_err", 64'(err), 64'd1);
        check_val("t5_hold", 64'(pat_hold), 64'd1);
        check_val("t5_busy", 64'(busy), 64'd0);

        // 5b. abort in the WRITE cycle: write still happens, no done
        clear_log();
        start_load(10'h030, 11'd2);
        check_val("t5b_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i), 0);
        byte_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check_val("t5b_nwr", 64'(wr_adr.size()), 64'd1);
        check_wr("t5b_w0", 0, 10'h030, 40'h25_2423_2221);
        check_val("t5b_ndone", 64'(done_cnt), 64'd0);
        check_val("t5b_err", 64'(err), 64'd1);
        check_val("t5b_hold", 64'(pat_hold), 64'd1);

        // 5c. clean load clears err and releases the PAT
        clear_log();
        start_load(10'h010, 11'd2);
        send_lines(2, 8'h01, 1'b0, 1'b0);
        wait_done("t5c_done");
        check_val("t5c_err", 64'(err), 64'd0);
        check_val("t5c_hold", 64'(pat_hold), 64'd0);

        // count == 0: done the cycle after the start is taken, no writes
        clear_log();
        start_load(10'h070, 11'd0);
        @(negedge clk);
        check_val("z_done", 64'(done), 64'd1);
        check_val("z_hold", 64'(pat_hold), 64'd0);
        tick();
        check_val("z_done_pulse", 64'(done), 64'd0);
        check_val("z_busy", 64'(busy), 64'd0);
        check_val("z_nwr", 64'(wr_adr.size()), 64'd0);

        // reset in the middle of COLLECT
        clear_log();
        start_load(10'h040, 11'd2);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        byte_valid = 1'b0;
        reset = 1'b0;
        tick();
        check_val("mr_busy", 64'(busy), 64'd0);
        check_val("mr_hold", 64'(pat_hold), 64'd1);
        check_val("mr_ready", 64'(byte_ready), 64'd0);
        reset = 1'b1;
        tick();
        start_load(10'h050, 11'd1);
        send_lines(1, 8'hA1, 1'b0, 1'b0);
        wait_done("mr_done");
        check_val("mr_nwr", 64'(wr_adr.size()), 64'd1);
        check_wr("mr_w0", 0, 10'h050, 40'hA5_A4A3_A2A1);
        check_val("mr_hold_after", 64'(pat_hold), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // 6. checksum accept and reject
        clear_log();
        start_load(10'h060, 11'd1);
        for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i), 0);
        send_byte(8'hF1, 0);
        byte_valid = 1'b0;
        wait_done("ck_good_done");
        check_val("ck_good_err", 64'(err), 64'd0);
        check_val("ck_good_hold", 64'(pat_hold), 64'd0);

        clear_log();
        start_load(10'h060, 11'd1);
        for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i), 0);
        send_byte(8'hF0, 0);
        byte_valid = 1'b0;
        wait_done("ck_bad_done");
        check_val("ck_bad_err", 64'(err), 64'd1);
        check_val("ck_bad_hold", 64'(pat_hold), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
